// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller: debounced buttons, state machine and
// 100 Hz single-cycle count-enable divider for the BCD counter / display latch.
module stopwatch_ctrl #(
  parameter int DEB_CNTMAX  = 499999,
  parameter int TICK_CNTMAX = 499999
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       cnt_max,
  output logic       tick,
  output logic       cnt_clr,
  output logic       hold,
  output logic       run,
  output logic [1:0] state
);

  localparam int DW = $clog2(DEB_CNTMAX + 2);
  localparam int TW = $clog2(TICK_CNTMAX + 2);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNTMAX);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CNTMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_DONE
  } state_e;

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_lap, btn_start};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          press_q;
    logic [DW-1:0] deb_cnt_q;

    // Counter runs only while the synchronised level disagrees with the accepted
    // one; any return to agreement restarts the stability window.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q     <= 1'b1;
        sync2_q     <= 1'b1;
        level_q     <= 1'b1;
        level_dly_q <= 1'b1;
        press_q     <= 1'b0;
        deb_cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_MAX) begin
          level_q   <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DW'(1);
        end
        level_dly_q <= level_q;
        press_q     <= level_dly_q & ~level_q;
      end
    end

    assign press[gi] = press_q;
  end

  logic start_press;
  logic lap_press;

  assign start_press = press[0];
  assign lap_press   = press[1];

  state_e        state_q, state_d;
  logic [TW-1:0] div_q, div_d;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    run     = 1'b0;
    hold    = 1'b0;
    state   = 2'd0;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        state   = 2'd0;
        if (start_press) state_d = S_RUN;
      end
      S_RUN: begin
        run   = 1'b1;
        state = 2'd1;
        if (cnt_max)          state_d = S_DONE;
        else if (start_press) state_d = S_PAUSE;
        else if (lap_press)   state_d = S_LAP;
      end
      S_LAP: begin
        run   = 1'b1;
        hold  = 1'b1;
        state = 2'd2;
        if (cnt_max)          state_d = S_DONE;
        else if (start_press) state_d = S_PAUSE;
        else if (lap_press)   state_d = S_RUN;
      end
      S_PAUSE: begin
        state = 2'd3;
        if (start_press)    state_d = S_RUN;
        else if (lap_press) state_d = S_IDLE;
      end
      S_DONE: begin
        state = 2'd3;
        if (lap_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider phase survives PAUSE/DONE so a resumed run keeps its partial period.
  always_comb begin
    div_d = div_q;
    if (state_q == S_IDLE) begin
      div_d = '0;
    end else if (run) begin
      div_d = (div_q == TICK_MAX) ? '0 : div_q + TW'(1);
    end
  end

  assign tick = run & (div_q == TICK_MAX);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations plus
// randomized button/cnt_max/reset activity checked every cycle against a model.
module tb_stopwatch_ctrl;

  localparam int DEB  = 3;
  localparam int TMAX = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_lap;
  logic       cnt_max;
  logic       tick;
  logic       cnt_clr;
  logic       hold;
  logic       run;
  logic [1:0] state;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_en = 1'b0;
  bit  start_busy = 1'b0;
  bit  lap_busy = 1'b0;

  stopwatch_ctrl #(
    .DEB_CNTMAX (DEB),
    .TICK_CNTMAX(TMAX)
  ) dut (
    .clk_50M  (clk),
    .rst_n    (rst_n),
    .btn_start(btn_start),
    .btn_lap  (btn_lap),
    .cnt_max  (cnt_max),
    .tick     (tick),
    .cnt_clr  (cnt_clr),
    .hold     (hold),
    .run      (run),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: states 0 idle, 1 run, 2 lap, 3 pause, 4 done.
  // A button level is accepted once the last DEB+1 synchronised samples all
  // disagree with the accepted level; the press reaches the FSM two edges later.
  int m_st = 0;
  int m_phase = 0;
  bit m_hist[2][2];
  bit m_win[2][DEB+1];
  bit m_acc[2];
  bit m_fell[2][2];
  bit mo_clr, mo_run, mo_hold, mo_tick;
  int mo_state;

  always @(posedge clk or negedge rst_n) begin
    bit ev[2];
    bit raw, sv, all_diff, running;
    if (!rst_n) begin
      m_st    = 0;
      m_phase = 0;
      for (int b = 0; b < 2; b++) begin
        m_acc[b] = 1'b1;
        m_hist[b][0] = 1'b1;
        m_hist[b][1] = 1'b1;
        m_fell[b][0] = 1'b0;
        m_fell[b][1] = 1'b0;
        for (int i = 0; i <= DEB; i++) m_win[b][i] = 1'b1;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? btn_start : btn_lap;
        ev[b] = m_fell[b][1];
        m_fell[b][1] = m_fell[b][0];
        sv = m_hist[b][1];
        m_hist[b][1] = m_hist[b][0];
        m_hist[b][0] = raw;
        for (int i = DEB; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = sv;
        all_diff = 1'b1;
        for (int i = 0; i <= DEB; i++) if (m_win[b][i] == m_acc[b]) all_diff = 1'b0;
        m_fell[b][0] = 1'b0;
        if (all_diff) begin
          m_fell[b][0] = m_acc[b] & ~sv;
          m_acc[b] = sv;
        end
      end
      running = (m_st == 1) || (m_st == 2);
      if (m_st == 0) m_phase = 0;
      else if (running) m_phase = (m_phase + 1) % (TMAX + 1);
      case (m_st)
        0: if (ev[0]) m_st = 1;
        1, 2: begin
          if (cnt_max)    m_st = 4;
          else if (ev[0]) m_st = 3;
          else if (ev[1]) m_st = (m_st == 1) ? 2 : 1;
        end
        3: begin
          if (ev[0])      m_st = 1;
          else if (ev[1]) m_st = 0;
        end
        default: if (ev[1]) m_st = 0;
      endcase
    end
    mo_state = (m_st == 4) ? 3 : m_st;
    mo_clr   = (m_st == 0);
    mo_run   = (m_st == 1) || (m_st == 2);
    mo_hold  = (m_st == 2);
    mo_tick  = mo_run && (m_phase == TMAX);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_state", int'(state), mo_state);
      check("model_cnt_clr", int'(cnt_clr), int'(mo_clr));
      check("model_run", int'(run), int'(mo_run));
      check("model_hold", int'(hold), int'(mo_hold));
      check("model_tick", int'(tick), int'(mo_tick));
    end
  end

  task automatic press(input int which, input int len);
    fork
      begin
        automatic int w = which;
        automatic int l = len;
        if (w == 0) begin start_busy = 1'b1; btn_start = 1'b0; end
        else        begin lap_busy = 1'b1;   btn_lap = 1'b0;   end
        repeat (l) @(negedge clk);
        if (w == 0) begin btn_start = 1'b1; start_busy = 1'b0; end
        else        begin btn_lap = 1'b1;   lap_busy = 1'b0;   end
      end
    join_none
  endtask

  task automatic wait_state(input int s, input int limit, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (int'(state) != s && k < limit);
    check("wait_state", int'(state), s);
  endtask

  task automatic ticks_from_here(output int n);
    n = 1;
    while (!tick && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    check({nm, "_state"}, int'(state), 0);
    check({nm, "_cnt_clr"}, int'(cnt_clr), 1);
    check({nm, "_run"}, int'(run), 0);
    check({nm, "_hold"}, int'(hold), 0);
    check({nm, "_tick"}, int'(tick), 0);
  endtask

  initial begin
    int k, n;
    rst_n = 1'b0;
    btn_start = 1'b1;
    btn_lap = 1'b1;
    cnt_max = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) n++;
    end
    check("idle_ticks", n, 0);
    check("idle_state", int'(state), 0);
    check("idle_cnt_clr", int'(cnt_clr), 1);

    press(0, 20);
    wait_state(1, 40, k);
    check("press_latency", k, 8);
    ticks_from_here(n);
    check("first_tick", n, 10);
    @(negedge clk);
    ticks_from_here(n);
    check("tick_period", n, 10);
    repeat (20) @(negedge clk);
    check("release_no_event", int'(state), 1);

    press(1, 6);
    wait_state(2, 40, k);
    check("lap_hold", int'(hold), 1);
    ticks_from_here(n);
    @(negedge clk);
    ticks_from_here(n);
    check("lap_tick_period", n, 10);
    repeat (10) @(negedge clk);
    press(1, 6);
    wait_state(1, 40, k);
    check("lap_back_hold", int'(hold), 0);
    repeat (10) @(negedge clk);
    press(0, 6);
    wait_state(3, 40, k);
    check("pause_run", int'(run), 0);
    repeat (10) @(negedge clk);
    press(1, 6);
    wait_state(0, 40, k);
    check("pause_lap_cnt_clr", int'(cnt_clr), 1);
    repeat (10) @(negedge clk);

    repeat (5) begin
      press(0, 3);
      repeat (8) @(negedge clk);
    end
    check("glitch_state", int'(state), 0);
    press(0, 4);
    wait_state(1, 40, k);
    check("min_press_latency", k, 8);

    // Start press on run cycle 9 lands the pause with the divider at 6.
    repeat (8) @(negedge clk);
    press(0, 4);
    wait_state(3, 40, k);
    repeat (10) @(negedge clk);
    press(0, 4);
    wait_state(1, 40, k);
    ticks_from_here(n);
    check("resume_tick", n, 4);

    repeat (3) @(negedge clk);
    cnt_max = 1'b1;
    @(negedge clk);
    cnt_max = 1'b0;
    check("done_state", int'(state), 3);
    check("done_run", int'(run), 0);
    check("done_cnt_clr", int'(cnt_clr), 0);
    n = 0;
    press(0, 6);
    repeat (30) begin
      @(negedge clk);
      if (tick) n++;
    end
    check("done_ticks", n, 0);
    check("done_ignores_start", int'(state), 3);
    press(0, 6);
    press(1, 6);
    wait_state(0, 40, k);
    check("done_both_latency", k, 8);
    repeat (10) @(negedge clk);
    press(0, 6);
    wait_state(1, 40, k);
    repeat (10) @(negedge clk);
    press(0, 6);
    wait_state(3, 40, k);
    repeat (10) @(negedge clk);
    press(0, 6);
    press(1, 6);
    wait_state(1, 40, k);
    check("pause_both_latency", k, 8);

    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", int'(state), 0);

    repeat (3000) begin
      @(negedge clk);
      if (!start_busy && $urandom_range(0, 29) == 0) press(0, int'($urandom_range(1, 15)));
      if (!lap_busy && $urandom_range(0, 39) == 0) press(1, int'($urandom_range(1, 15)));
      cnt_max = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    repeat (20) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
